// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: handshake bundle for the round-robin registered selector.
// Producers on in_*, consumer on out_*.
interface rr_mux_reg_if #(
  parameter int width    = 32,
  parameter int channels = 4
);
  localparam int selw = $clog2(channels);

  logic [channels*width-1:0] in_data;
  logic [channels-1:0]       in_valid;
  logic [channels-1:0]       in_ready;
  logic [width-1:0]          out_data;
  logic [selw-1:0]           out_sel;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel round-robin selector with a one-entry output register.
// Define RR_MUX_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module rr_mux_reg #(
  parameter int width    = 32,
  parameter int channels = 4
) (
  input  logic         clk,
  input  logic         reset,
  rr_mux_reg_if.slave  bus
);
  localparam int selw = $clog2(channels);
  localparam logic [selw:0] nch = (selw+1)'(channels);
  localparam logic [selw-1:0] last = selw'(channels - 1);

  logic              ld;
  logic              hit;
  logic [selw-1:0]   gnt;
  logic [selw:0]     idx;
  logic [width-1:0]  gnt_data;
  logic [selw-1:0]   ptr;

  logic [width-1:0]  dat_q;
  logic [selw-1:0]   sel_q;
  logic              vld_q;

  assign ld = !vld_q || bus.out_ready;

  assign bus.out_data  = dat_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = vld_q;

  // Scan requests starting at ptr, wrapping at channels; first hit wins.
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < channels; i++) begin
      idx = {1'b0, ptr} + (selw+1)'(i);
      if (idx >= nch)
        idx = idx - nch;
      if (!hit && bus.in_valid[idx[selw-1:0]]) begin
        hit = 1'b1;
        gnt = idx[selw-1:0];
      end
    end
  end

  // Route the granted word and raise ready only on the granted channel.
  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int k = 0; k < channels; k++) begin
      if (gnt == selw'(k)) begin
        gnt_data = bus.in_data[k*width +: width];
        bus.in_ready[k] = ld && hit && !reset;
      end
    end
  end

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // Rotate the scan start to just past the last winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (ld && hit)
      ptr <= (gnt == last) ? '0 : gnt + 1'b1;
  end
`endif

  // Output register: load on grant, drain when idle, hold under back-pressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
    end else if (ld) begin
      if (hit) begin
        dat_q <= gnt_data;
        sel_q <= gnt;
        vld_q <= 1'b1;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed table plus corner sequences for rr_mux_reg.
// Covers 4- and 3-channel instances.
module tb_rr_mux_reg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_mux_reg_if #(.width(32), .channels(4)) b4 ();
  rr_mux_reg_if #(.width(32), .channels(3)) b3 ();

  rr_mux_reg #(.width(32), .channels(4)) u4 (
    .clk(clk), .reset(reset), .bus(b4)
  );
  rr_mux_reg #(.width(32), .channels(3)) u3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  typedef struct {
    logic [3:0]  v;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [31:0] dat;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic [3:0] v, logic ordy, logic [3:0] rdy,
                              logic ov, logic [1:0] sel, logic [31:0] dat);
    vec_t r;
    r.v = v; r.ordy = ordy; r.rdy = rdy;
    r.ov = ov; r.sel = sel; r.dat = dat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] v, input logic ordy,
                        input logic [7:0] tag);
    b4.in_valid = v;
    b4.out_ready = ordy;
    for (int k = 0; k < 4; k++)
      b4.in_data[k*32 +: 32] = {tag, 8'(k), 16'hBEEF};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive4(4'b0000, 1'b1, 8'h00);
    b3.in_valid = '0;
    b3.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [1:0] rot_exp[6];
  logic [1:0] rot3_exp[4];
  logic [3:0] bp_last;
  logic [1:0] bp_sel;

  initial begin
    b4.in_data = '0;
    b4.in_valid = '0;
    b4.out_ready = 1'b0;
    b3.in_data = '0;
    b3.in_valid = '0;
    b3.out_ready = 1'b0;

    tbl[0] = mk(4'b0000, 1, 4'b0000, 0, 2'd0, 32'h0);
    tbl[1] = mk(4'b0100, 1, 4'b0100, 1, 2'd2, 32'h0102BEEF);
`ifdef RR_MUX_FIXED_PRIO_EN
    tbl[2] = mk(4'b1111, 1, 4'b0001, 1, 2'd0, 32'h0200BEEF);
    tbl[3] = mk(4'b1111, 1, 4'b0001, 1, 2'd0, 32'h0300BEEF);
    tbl[4] = mk(4'b1111, 1, 4'b0001, 1, 2'd0, 32'h0400BEEF);
    tbl[5] = mk(4'b1010, 0, 4'b0000, 1, 2'd0, 32'h0400BEEF);
    tbl[6] = mk(4'b1010, 1, 4'b0010, 1, 2'd1, 32'h0601BEEF);
    tbl[7] = mk(4'b0000, 1, 4'b0000, 0, 2'd1, 32'h0601BEEF);
    tbl[8] = mk(4'b0000, 0, 4'b0000, 0, 2'd1, 32'h0601BEEF);
    rot_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    rot3_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
    bp_last = 4'b0010;
    bp_sel = 2'd1;
`else
    tbl[2] = mk(4'b1111, 1, 4'b1000, 1, 2'd3, 32'h0203BEEF);
    tbl[3] = mk(4'b1111, 1, 4'b0001, 1, 2'd0, 32'h0300BEEF);
    tbl[4] = mk(4'b1111, 1, 4'b0010, 1, 2'd1, 32'h0401BEEF);
    tbl[5] = mk(4'b1010, 0, 4'b0000, 1, 2'd1, 32'h0401BEEF);
    tbl[6] = mk(4'b1010, 1, 4'b1000, 1, 2'd3, 32'h0603BEEF);
    tbl[7] = mk(4'b0000, 1, 4'b0000, 0, 2'd3, 32'h0603BEEF);
    tbl[8] = mk(4'b0000, 0, 4'b0000, 0, 2'd3, 32'h0603BEEF);
    rot_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rot3_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
    bp_last = 4'b1000;
    bp_sel = 2'd3;
`endif
    tbl[9] = mk(4'b0001, 0, 4'b0001, 1, 2'd0, 32'h0900BEEF);

    // reset state, async
    #2;
    chk("rst_ov", 32'(b4.out_valid), 32'h0);
    chk("rst_ready", 32'(b4.in_ready), 32'h0);
    do_reset();

    // table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive4(tbl[i].v, tbl[i].ordy, 8'(i));
      #1;
      chk($sformatf("t%0d_rdy", i), 32'(b4.in_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_ov", i), 32'(b4.out_valid), 32'(tbl[i].ov));
      chk($sformatf("t%0d_sel", i), 32'(b4.out_sel), 32'(tbl[i].sel));
      chk($sformatf("t%0d_dat", i), b4.out_data, tbl[i].dat);
    end

    // rotation with all channels requesting
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive4(4'b1111, 1'b1, 8'h10);
      #1;
      chk($sformatf("rot%0d_rdy", i), 32'(b4.in_ready),
          32'(4'b0001 << rot_exp[i]));
      @(posedge clk);
      #1;
      chk($sformatf("rot%0d_sel", i), 32'(b4.out_sel), 32'(rot_exp[i]));
    end

    // back-pressure: ch1 loads, held 3 cycles, then next grant with no bubble
    do_reset();
    @(negedge clk);
    drive4(4'b1010, 1'b0, 8'h20);
    #1;
    chk("bp_load_rdy", 32'(b4.in_ready), 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_rdy", i), 32'(b4.in_ready), 32'h0);
      chk($sformatf("bp%0d_sel", i), 32'(b4.out_sel), 32'h1);
      chk($sformatf("bp%0d_ov", i), 32'(b4.out_valid), 32'h1);
    end
    @(negedge clk);
    b4.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(b4.in_ready), 32'(bp_last));
    @(posedge clk);
    #1;
    chk("bp_rel_ov", 32'(b4.out_valid), 32'h1);
    chk("bp_rel_sel", 32'(b4.out_sel), 32'(bp_sel));

    // single source with a distinctive word
    do_reset();
    @(negedge clk);
    drive4(4'b0100, 1'b1, 8'h30);
    b4.in_data[2*32 +: 32] = 32'hDEADBEEF;
    #1;
    chk("single_rdy", 32'(b4.in_ready), 32'h4);
    @(posedge clk);
    #1;
    chk("single_ov", 32'(b4.out_valid), 32'h1);
    chk("single_dat", b4.out_data, 32'hDEADBEEF);
    chk("single_sel", 32'(b4.out_sel), 32'h2);

    // async reset while a word is held
    @(negedge clk);
    drive4(4'b1111, 1'b0, 8'h40);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_ov", 32'(b4.out_valid), 32'h0);
    chk("arst_dat", b4.out_data, 32'h0);
    chk("arst_sel", 32'(b4.out_sel), 32'h0);
    chk("arst_rdy", 32'(b4.in_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    b4.out_ready = 1'b1;
    #1;
    chk("arst_next_rdy", 32'(b4.in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("arst_next_sel", 32'(b4.out_sel), 32'h0);

    // three-channel wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b3.in_valid = 3'b111;
      b3.out_ready = 1'b1;
      for (int k = 0; k < 3; k++)
        b3.in_data[k*32 +: 32] = 32'h5000_0000 + 32'(k);
      #1;
      chk($sformatf("w3_%0d_rdy", i), 32'(b3.in_ready),
          32'(3'b001 << rot3_exp[i]));
      @(posedge clk);
      #1;
      chk($sformatf("w3_%0d_sel", i), 32'(b3.out_sel), 32'(rot3_exp[i]));
      chk($sformatf("w3_%0d_dat", i), b3.out_data,
          32'h5000_0000 + 32'(rot3_exp[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
